rgb_scan_out: RTL and testbench
===============================

# rgb_scan_out

Display scan-out engine sitting directly downstream of the display FIFO (8-bit write side from the i8080 bus, 16-bit read side). It generates RGB panel timing (HSYNC/VSYNC/DE) from free-running pixel counters. During the active region it pops one 16-bit RGB565 word per clock from the FIFO and drives it onto the panel bus, aligned with the sync signals. It flags FIFO underflow.

## Interface
Parameters:
- H_ACTIVE, 480, visible pixels per line
- H_FP, 8, horizontal front porch (clocks)
- H_SYNC, 4, HSYNC width (clocks)
- H_BP, 43, horizontal back porch (clocks)
- V_ACTIVE, 272, visible lines per frame
- V_FP, 4, vertical front porch (lines)
- V_SYNC, 4, VSYNC width (lines)
- V_BP, 12, vertical back porch (lines)

Ports:
- clk  in  1  pixel clock; also the FIFO read clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  scan enable; low holds counters at 0
- fifo_do  in  16  FIFO read data, RGB565; valid the cycle after fifo_re
- fifo_empty  in  1  FIFO empty flag
- fifo_re  out  1  FIFO read enable (combinational)
- lcd_r  out  5  red (pixel[15:11])
- lcd_g  out  6  green (pixel[10:5])
- lcd_b  out  5  blue (pixel[4:0])
- lcd_hs  out  1  HSYNC, active-low
- lcd_vs  out  1  VSYNC, active-low
- lcd_de  out  1  data enable, active-high
- frame_start  out  1  one-cycle pulse on the first output cycle of each frame
- underflow  out  1  sticky underflow flag
- underflow_clr  in  1  synchronous clear of underflow

## Operation
- Totals: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP.
- Counters: h_cnt runs 0..H_TOTAL-1 and wraps to 0. v_cnt increments when h_cnt wraps and wraps to 0 after V_TOTAL-1.
- Line layout: sync [0, H_SYNC), back porch, active [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE), front porch. Vertical layout is identical using lines.
- active = h in active range AND v in active range.
- fifo_re = en & active & ~fifo_empty.
- Underflow: when active and fifo_empty, no read is issued. The pixel output for that slot is 16'h0000 and underflow is set. underflow stays set until underflow_clr or rst. If underflow_clr and a new underflow event occur in the same cycle, set wins.
- en low: counters are synchronously forced to 0 and fifo_re is 0. Pipeline stages drain with lcd_de=0, lcd_hs=1, lcd_vs=1. When en rises, the frame restarts at h=0, v=0.
- No line or frame resynchronisation with the FIFO contents. The upstream writer must keep the FIFO pixel-aligned with frame_start.

## Timing
- Stage 0 (cycle n): counters give hs/vs/active; fifo_re is issued.
- Stage 1 (edge ending cycle n): registers hs, vs, de, a read-taken flag, and the frame-start condition (h=0 & v=0 & en).
- Stage 2 (edge ending cycle n+1): samples fifo_do if read-taken, else 0. Registers it with the delayed syncs.
- Every output lags its counter state by exactly 2 clocks, and all outputs stay mutually aligned.
- Reset values: lcd_r/g/b=0, lcd_hs=1, lcd_vs=1, lcd_de=0, frame_start=0, underflow=0, counters 0. fifo_re=0 while rst is high.
- Reset mid-frame clears all state asynchronously. The first cycle after release is h=0, v=0 (if en=1).
- Back-to-back active pixels read on consecutive cycles with no bubbles.

## Configuration
- RGB_SCAN_TESTPATTERN_EN defined: adds input port test_mode (1 bit).
  - When test_mode=1, fifo_re is forced 0 and underflow is never set.
  - Active pixels become {x[4:0], y[5:0], ~x[4:0]}, where x = h_cnt-(H_SYNC+H_BP) and y = v_cnt-(V_SYNC+V_BP).
  - The pattern goes through the same 2-stage pipeline.
- Macro undefined: there is no test_mode port, and behaviour is as described above.

## Test plan
Bench parameters: H_ACTIVE=4, H_FP=1, H_SYNC=1, H_BP=1 (H_TOTAL=7); V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=5).

- Reset then en=1, FIFO never empty, fifo_do = incrementing count:
  - frame_start pulses every 35 clocks.
  - lcd_hs is low 1 of every 7 clocks; lcd_vs is low for 7 clocks per frame.
  - lcd_de is high for 4 consecutive clocks on 2 lines per frame.
  - fifo_re is asserted exactly 8 times per frame.
- Latency and alignment: the first fifo_re falls at h=2, v=2. The matching pixel (fifo_do=16'hF81F) appears 2 clocks later as lcd_r=31, lcd_g=0, lcd_b=31 with lcd_de=1.
- Underflow: fifo_empty=1 during the 3rd active pixel of a line:
  - No fifo_re that cycle.
  - The output pixel 2 clocks later is 0 with lcd_de=1.
  - underflow rises and holds until underflow_clr.
- Simultaneous underflow_clr and a new underflow event: underflow stays 1.
- rst pulsed mid-active-line:
  - Outputs go immediately to their reset values (hs=1, vs=1, de=0, rgb=0).
  - The frame restarts at h=0, v=0 after release, and frame_start pulses 2 clocks later.
- With RGB_SCAN_TESTPATTERN_EN and test_mode=1, fifo_empty=1:
  - fifo_re is never asserted and underflow stays 0.
  - The pixel at x=3, y=1 outputs {5'd3, 6'd1, 5'd28}.

Source files
------------

// File: rtl/rgb_scan_out_if.sv
//==============================================================================
// Module   : rgb_scan_out_if
// Desc     : FIFO read side and RGB panel bus of the display scan-out engine.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface rgb_scan_out_if;
    logic [15:0] fifo_do;
    logic        fifo_empty;
    logic        fifo_re;
    logic [4:0]  lcd_r;
    logic [5:0]  lcd_g;
    logic [4:0]  lcd_b;
    logic        lcd_hs;
    logic        lcd_vs;
    logic        lcd_de;

    modport master (
        input  fifo_do, fifo_empty,
        output fifo_re, lcd_r, lcd_g, lcd_b, lcd_hs, lcd_vs, lcd_de
    );

    modport slave (
        output fifo_do, fifo_empty,
        input  fifo_re, lcd_r, lcd_g, lcd_b, lcd_hs, lcd_vs, lcd_de
    );
endinterface

`default_nettype wire

// File: rtl/rgb_scan_out.sv
//==============================================================================
// Module   : rgb_scan_out
// Desc     : RGB panel timing generator popping one RGB565 word per active clock
//            from the display FIFO; outputs lag the counters by two clocks.
// Config   : RGB_SCAN_TESTPATTERN_EN adds test_mode (internal x/y pattern).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module rgb_scan_out #(
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 4,
    parameter int H_BP     = 43,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
`ifdef RGB_SCAN_TESTPATTERN_EN
    input  logic             test_mode,
`endif
    rgb_scan_out_if.master   bus,
    output logic             frame_start,
    output logic             underflow,
    input  logic             underflow_clr
);

    localparam int c_h_total = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int c_v_total = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int c_hw      = (c_h_total > 1) ? $clog2(c_h_total) : 1;
    localparam int c_vw      = (c_v_total > 1) ? $clog2(c_v_total) : 1;

    localparam logic [c_hw-1:0] c_h_last    = c_hw'(c_h_total - 1);
    localparam logic [c_hw-1:0] c_h_sync_hi = c_hw'(H_SYNC - 1);
    localparam logic [c_hw-1:0] c_h_act_lo  = c_hw'(H_SYNC + H_BP);
    localparam logic [c_hw-1:0] c_h_act_hi  = c_hw'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [c_vw-1:0] c_v_last    = c_vw'(c_v_total - 1);
    localparam logic [c_vw-1:0] c_v_sync_hi = c_vw'(V_SYNC - 1);
    localparam logic [c_vw-1:0] c_v_act_lo  = c_vw'(V_SYNC + V_BP);
    localparam logic [c_vw-1:0] c_v_act_hi  = c_vw'(V_SYNC + V_BP + V_ACTIVE - 1);

    logic [c_hw-1:0] r_h;
    logic [c_vw-1:0] r_v;

    logic        w_test;
    logic        w_h_sync;
    logic        w_v_sync;
    logic        w_active;
    logic        w_re;
    logic        w_uf_event;
    logic [4:0]  w_x;
    logic [5:0]  w_y;
    logic [15:0] w_pat;

    logic        r_hs1, r_vs1, r_de1, r_rd1, r_fs1;
    logic [15:0] r_pat1;
    logic        r_hs2, r_vs2, r_de2, r_fs2;
    logic [15:0] r_pix;
    logic        r_uf;

`ifdef RGB_SCAN_TESTPATTERN_EN
    assign w_test = test_mode;
`else
    assign w_test = 1'b0;
`endif

    // Free-running raster counters; en low parks them at the frame origin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (!en) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == c_h_last) begin
            r_h <= '0;
            r_v <= (r_v == c_v_last) ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    assign w_h_sync   = (r_h <= c_h_sync_hi);
    assign w_v_sync   = (r_v <= c_v_sync_hi);
    assign w_active   = en && (r_h >= c_h_act_lo) && (r_h <= c_h_act_hi)
                           && (r_v >= c_v_act_lo) && (r_v <= c_v_act_hi);
    assign w_re       = !rst && w_active && !bus.fifo_empty && !w_test;
    assign w_uf_event = w_active && bus.fifo_empty && !w_test;

    assign w_x   = 5'({5'd0, r_h} - (c_hw + 5)'(H_SYNC + H_BP));
    assign w_y   = 6'({6'd0, r_v} - (c_vw + 6)'(V_SYNC + V_BP));
    assign w_pat = {w_x, w_y, ~w_x};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hs1  <= 1'b1;
            r_vs1  <= 1'b1;
            r_de1  <= 1'b0;
            r_rd1  <= 1'b0;
            r_fs1  <= 1'b0;
            r_pat1 <= '0;
        end else begin
            r_hs1  <= ~(en & w_h_sync);
            r_vs1  <= ~(en & w_v_sync);
            r_de1  <= w_active;
            r_rd1  <= w_re;
            r_fs1  <= en && (r_h == '0) && (r_v == '0);
            r_pat1 <= (w_active && w_test) ? w_pat : 16'h0000;
        end
    end

    // FIFO data arrives the cycle after the read; a skipped slot outputs r_pat1 (zero outside test mode).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hs2 <= 1'b1;
            r_vs2 <= 1'b1;
            r_de2 <= 1'b0;
            r_fs2 <= 1'b0;
            r_pix <= '0;
        end else begin
            r_hs2 <= r_hs1;
            r_vs2 <= r_vs1;
            r_de2 <= r_de1;
            r_fs2 <= r_fs1;
            r_pix <= r_rd1 ? bus.fifo_do : r_pat1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_uf <= 1'b0;
        end else if (w_uf_event) begin
            r_uf <= 1'b1;
        end else if (underflow_clr) begin
            r_uf <= 1'b0;
        end
    end

    assign bus.fifo_re = w_re;
    assign bus.lcd_r   = r_pix[15:11];
    assign bus.lcd_g   = r_pix[10:5];
    assign bus.lcd_b   = r_pix[4:0];
    assign bus.lcd_hs  = r_hs2;
    assign bus.lcd_vs  = r_vs2;
    assign bus.lcd_de  = r_de2;
    assign frame_start = r_fs2;
    assign underflow   = r_uf;

endmodule

`default_nettype wire

// File: tb/tb_rgb_scan_out.sv
//==============================================================================
// Module   : tb_rgb_scan_out
// Desc     : Self-checking bench for rgb_scan_out on a 7x5 raster.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rgb_scan_out;

    localparam int c_HT = 7;
    localparam int c_VT = 5;
    localparam int c_FT = c_HT * c_VT;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic underflow_clr;
    logic test_mode;
    logic frame_start;
    logic underflow;

    rgb_scan_out_if bus();

    rgb_scan_out #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
`ifdef RGB_SCAN_TESTPATTERN_EN
        .test_mode    (test_mode),
`endif
        .bus          (bus),
        .frame_start  (frame_start),
        .underflow    (underflow),
        .underflow_clr(underflow_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic [15:0] pix;
    } out_t;

    out_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          t, cyc;
    logic [15:0] data_next;
    logic        m_uf;
    int          win_lo, win_hi;
    int          cnt_hs, cnt_vs, cnt_de, cnt_re, cnt_fs;
    int          fs_prev, fs_gap, first_re;
    logic [15:0] obs_pix;
    logic        obs_de, obs_uf;
    logic [15:0] pat_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_hs",  32'(bus.lcd_hs),  32'(1));
        check("rst_vs",  32'(bus.lcd_vs),  32'(1));
        check("rst_de",  32'(bus.lcd_de),  32'(0));
        check("rst_rgb", 32'({bus.lcd_r, bus.lcd_g, bus.lcd_b}), 32'(0));
        check("rst_fs",  32'(frame_start), 32'(0));
        check("rst_uf",  32'(underflow),   32'(0));
        check("rst_re",  32'(bus.fifo_re), 32'(0));
    endtask

    task automatic model_restart();
        t       = 0;
        cyc     = 0;
        m_uf    = 1'b0;
        fs_prev = -1;
        fs_gap  = -1;
        first_re = -1;
        exp_q.delete();
        exp_q.push_back('{hs: 1'b1, vs: 1'b1, de: 1'b0, fs: 1'b0, pix: 16'h0});
        exp_q.push_back('{hs: 1'b1, vs: 1'b1, de: 1'b0, fs: 1'b0, pix: 16'h0});
    endtask

    task automatic clear_counts(input int lo, input int hi);
        win_lo = lo; win_hi = hi;
        cnt_hs = 0; cnt_vs = 0; cnt_de = 0; cnt_re = 0; cnt_fs = 0;
    endtask

    // One pixel clock: compare outputs with the value predicted two clocks ago,
    // predict this slot from raster position, then advance past the edge.
    task automatic cycle();
        out_t        e, cur;
        int          h, v;
        logic        act, re, ev;
        logic [15:0] popped;
        logic [4:0]  x;
        logic [5:0]  y;
        @(negedge clk);
        obs_pix = {bus.lcd_r, bus.lcd_g, bus.lcd_b};
        obs_de  = bus.lcd_de;
        obs_uf  = underflow;
        e = exp_q.pop_front();
        check("lcd_hs", 32'(bus.lcd_hs), 32'(e.hs));
        check("lcd_vs", 32'(bus.lcd_vs), 32'(e.vs));
        check("lcd_de", 32'(bus.lcd_de), 32'(e.de));
        check("frame_start", 32'(frame_start), 32'(e.fs));
        check("pixel", 32'(obs_pix), 32'(e.pix));
        check("underflow", 32'(underflow), 32'(m_uf));
        if (cyc >= win_lo && cyc < win_hi) begin
            if (!bus.lcd_hs) cnt_hs++;
            if (!bus.lcd_vs) cnt_vs++;
            if (bus.lcd_de)  cnt_de++;
            if (bus.fifo_re) cnt_re++;
            if (frame_start) cnt_fs++;
        end
        if (frame_start) begin
            if (fs_prev >= 0) fs_gap = cyc - fs_prev;
            fs_prev = cyc;
        end
        h   = t % c_HT;
        v   = (t / c_HT) % c_VT;
        act = en && h >= 2 && h < 6 && v >= 2 && v < 4;
        re  = act && !bus.fifo_empty && !test_mode;
        ev  = act && bus.fifo_empty && !test_mode;
        check("fifo_re", 32'(bus.fifo_re), 32'(re));
        if (bus.fifo_re && first_re < 0) first_re = cyc;
        cur.hs = !(en && h < 1);
        cur.vs = !(en && v < 1);
        cur.de = act;
        cur.fs = en && h == 0 && v == 0;
        popped = 16'h0;
        if (re) begin
            popped    = data_next;
            data_next = data_next + 16'd1;
            cur.pix   = popped;
        end else if (act && test_mode) begin
            x = 5'(h - 2);
            y = 6'(v - 2);
            cur.pix = {x, y, ~x};
        end else begin
            cur.pix = 16'h0;
        end
        exp_q.push_back(cur);
        if (ev) m_uf = 1'b1;
        else if (underflow_clr) m_uf = 1'b0;
        t = en ? t + 1 : 0;
        @(posedge clk);
        #1;
        bus.fifo_do = re ? popped : 16'($urandom);
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b1; underflow_clr = 1'b0; test_mode = 1'b0;
        bus.fifo_empty = 1'b0; bus.fifo_do = 16'h0;
        clear_counts(0, 0);
        data_next = 16'hF81F;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        #1 rst = 1'b0;
        model_restart();

        // Two full frames with a never-empty FIFO
        clear_counts(2, 2 + 2 * c_FT);
        repeat (2 + 2 * c_FT) cycle();
        check("cnt_fs", 32'(cnt_fs), 32'(2));
        check("fs_gap", 32'(fs_gap), 32'(c_FT));
        check("cnt_hs_low", 32'(cnt_hs), 32'(10));
        check("cnt_vs_low", 32'(cnt_vs), 32'(14));
        check("cnt_de", 32'(cnt_de), 32'(16));
        check("cnt_re", 32'(cnt_re), 32'(16));
        check("first_re_cyc", 32'(first_re), 32'(2 * c_HT + 2));
        clear_counts(0, 0);

        // First pixel latency, replayed on a fresh frame via en
        en = 1'b0; cycle(); en = 1'b1;
        cyc = 0; data_next = 16'hF81F;
        repeat (2 * c_HT + 2 + 3) cycle();
        check("first_pix_r", 32'(bus.lcd_r == 5'd31 ? 1 : 0) & 32'(obs_pix[15:11] == 5'd31), 32'(1));
        check("first_pix_g", 32'(obs_pix[10:5]), 32'(0));
        check("first_pix_b", 32'(obs_pix[4:0]), 32'(31));
        check("first_pix_de", 32'(obs_de), 32'(1));

        // Underflow on the third active pixel of a line
        while (t % c_FT != 2 * c_HT + 4) cycle();
        bus.fifo_empty = 1'b1; cycle(); bus.fifo_empty = 1'b0;
        cycle(); cycle();
        check("uf_pix", 32'(obs_pix), 32'(0));
        check("uf_de", 32'(obs_de), 32'(1));
        check("uf_set", 32'(obs_uf), 32'(1));
        repeat (10) cycle();
        check("uf_hold", 32'(obs_uf), 32'(1));
        underflow_clr = 1'b1; cycle(); underflow_clr = 1'b0; cycle();
        check("uf_clr", 32'(obs_uf), 32'(0));

        // Clear and new event in the same cycle: set wins
        while (t % c_FT != 2 * c_HT + 2) cycle();
        bus.fifo_empty = 1'b1; cycle();
        underflow_clr = 1'b1; cycle();
        bus.fifo_empty = 1'b0; underflow_clr = 1'b0; cycle();
        check("uf_set_wins", 32'(obs_uf), 32'(1));
        underflow_clr = 1'b1; cycle(); underflow_clr = 1'b0;

        // Randomized traffic: empties, clears and en drops
        for (int i = 0; i < 400; i++) begin
            en             = ($urandom % 32) != 0;
            bus.fifo_empty = ($urandom % 4) == 0;
            underflow_clr  = ($urandom % 8) == 0;
            cycle();
        end
        en = 1'b1; bus.fifo_empty = 1'b0; underflow_clr = 1'b0;

        // Asynchronous reset in the middle of an active line
        while (t % c_FT != 2 * c_HT + 5) cycle();
        check("pre_rst_de", 32'(bus.lcd_de), 32'(1));
        #1 rst = 1'b1;
        #1 check_reset_outputs();
        @(posedge clk);
        #2 rst = 1'b0;
        model_restart();
        repeat (6) cycle();
        check("rst_fs_lat", 32'(fs_prev), 32'(2));

`ifdef RGB_SCAN_TESTPATTERN_EN
        underflow_clr = 1'b1; cycle(); underflow_clr = 1'b0;
        test_mode = 1'b1; bus.fifo_empty = 1'b1;
        clear_counts(cyc, cyc + 1000);
        while (t % c_FT != 3 * c_HT + 5) cycle();
        repeat (3) cycle();
        pat_exp = {5'd3, 6'd1, 5'd28};
        check("tp_pix_x3_y1", 32'(obs_pix), 32'(pat_exp));
        repeat (40) cycle();
        check("tp_no_re", 32'(cnt_re), 32'(0));
        check("tp_no_uf", 32'(obs_uf), 32'(0));
        test_mode = 1'b0; bus.fifo_empty = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
